pipeline_hazard_controller: RTL and testbench

Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Drives the hold and clear controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Selects the branch/jump PC when a redirect resolves in MEM.
- Freezes the pipeline while a variable-latency data memory completes an access.
- Sits beside the pipeline registers, fed by their stage-tagged control and data fields.

---
 rtl/pipeline_hazard_controller.sv | 158 +++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline: load-use bubbles,
// MEM-stage redirects, and freeze on a variable-latency data memory access.
module pipeline_hazard_controller #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemRead_E,
  input  logic [4:0]       WriteReg_E,
  input  logic [4:0]       Rs_D,
  input  logic [4:0]       Rt_D,
  input  logic [1:0]       Jump_M,
  input  logic             BranchEQ_M,
  input  logic             BranchNE_M,
  input  logic             Zero_M,
  input  logic             MemRead_M,
  input  logic             MemWrite_M,
  input  logic             MemReady,
  output logic             Stall_F,
  output logic             Stall_D,
  output logic             Stall_E,
  output logic             Stall_M,
  output logic             Flush_D,
  output logic             Flush_E,
  output logic             Flush_M,
  output logic             Flush_W,
  output logic             PCSrc_M,
  output logic             Error,
  output logic [CNT_W-1:0] StallCount
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic flush_m;
    logic flush_w;
    logic pc_src;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE  = '0;
  localparam ctrl_t CTRL_HOLD  = '{stall_f: 1'b1, stall_d: 1'b1, stall_e: 1'b1,
                                   stall_m: 1'b1, flush_w: 1'b1, default: 1'b0};
  localparam ctrl_t CTRL_RESET = '{flush_d: 1'b1, flush_e: 1'b1, flush_m: 1'b1,
                                   flush_w: 1'b1, default: 1'b0};
  localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 1);

  state_t           state;
  state_t           state_next;
  logic [15:0]      wait_cnt;
  logic [15:0]      wait_cnt_next;
  logic             error_q;
  logic [CNT_W-1:0] stall_cnt;

  logic  mem_pending;
  logic  taken;
  logic  load_use;
  ctrl_t resolve;
  ctrl_t ctrl;

  assign mem_pending = (MemRead_M | MemWrite_M) & ~MemReady;
  assign taken       = (BranchEQ_M & Zero_M) | (BranchNE_M & ~Zero_M) | (Jump_M != 2'd0);
  assign load_use    = MemRead_E & (WriteReg_E != 5'd0) &
                       ((WriteReg_E == Rs_D) | (WriteReg_E == Rt_D));

  // Redirect beats load-use: the dependent instruction is being flushed anyway.
  always_comb begin
    resolve = CTRL_IDLE;
    if (taken) begin
      resolve.pc_src  = 1'b1;
      resolve.flush_d = 1'b1;
      resolve.flush_e = 1'b1;
      resolve.flush_m = 1'b1;
    end else if (load_use) begin
      resolve.stall_f = 1'b1;
      resolve.stall_d = 1'b1;
      resolve.flush_e = 1'b1;
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    ctrl          = CTRL_IDLE;
    unique case (state)
      RUN: begin
        if (mem_pending) begin
          ctrl          = CTRL_HOLD;
          state_next    = MEM_WAIT;
          wait_cnt_next = 16'd1;
        end else begin
          ctrl = resolve;
        end
      end
      MEM_WAIT: begin
        if (!MemReady) begin
          ctrl          = CTRL_HOLD;
          wait_cnt_next = wait_cnt + 16'd1;
          if (wait_cnt == WAIT_LAST) state_next = ERROR;
        end else begin
          ctrl          = resolve;
          state_next    = RUN;
          wait_cnt_next = 16'd0;
        end
      end
      ERROR: begin
        ctrl = CTRL_HOLD;
      end
      default: begin
        state_next    = RUN;
        wait_cnt_next = 16'd0;
      end
    endcase
    if (!reset) ctrl = CTRL_RESET;
  end

  // Negedge timing lines up with the pipeline registers this block controls.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(negedge clk) begin
    if (!reset) begin
      state     <= RUN;
      wait_cnt  <= 16'd0;
      error_q   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (state_next == ERROR) error_q <= 1'b1;
      if (ctrl.stall_f && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign Stall_F    = ctrl.stall_f;
  assign Stall_D    = ctrl.stall_d;
  assign Stall_E    = ctrl.stall_e;
  assign Stall_M    = ctrl.stall_m;
  assign Flush_D    = ctrl.flush_d;
  assign Flush_E    = ctrl.flush_e;
  assign Flush_M    = ctrl.flush_m;
  assign Flush_W    = ctrl.flush_w;
  assign PCSrc_M    = ctrl.pc_src;
  assign Error      = error_q;
  assign StallCount = stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: two instances (default and small
// parameters) against a cycle-level model of the hazard rules.
module tb_pipeline_hazard_controller;

  localparam int A_TIMEOUT = 16;
  localparam int A_CNT_W   = 16;
  localparam int B_TIMEOUT = 4;
  localparam int B_CNT_W   = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       MemRead_E;
  logic [4:0] WriteReg_E;
  logic [4:0] Rs_D;
  logic [4:0] Rt_D;
  logic [1:0] Jump_M;
  logic       BranchEQ_M;
  logic       BranchNE_M;
  logic       Zero_M;
  logic       MemRead_M;
  logic       MemWrite_M;
  logic       MemReady;

  logic [8:0]         a_ctrl;
  logic               a_err;
  logic [A_CNT_W-1:0] a_count;
  logic [8:0]         b_ctrl;
  logic               b_err;
  logic [B_CNT_W-1:0] b_count;

  int checks   = 0;
  int failures = 0;
  logic [8:0] last_a_ctrl;
  logic [8:0] last_b_ctrl;

  // Control vector order: Stall F D E M, Flush D E M W, PCSrc.
  localparam logic [8:0] C_IDLE   = 9'b0000_0000_0;
  localparam logic [8:0] C_RESET  = 9'b0000_1111_0;
  localparam logic [8:0] C_HOLD   = 9'b1111_0001_0;
  localparam logic [8:0] C_REDIR  = 9'b0000_1110_1;
  localparam logic [8:0] C_BUBBLE = 9'b1100_0100_0;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.MEM_TIMEOUT(A_TIMEOUT), .CNT_W(A_CNT_W)) dut_a (
    .clk(clk), .reset(reset), .MemRead_E(MemRead_E), .WriteReg_E(WriteReg_E),
    .Rs_D(Rs_D), .Rt_D(Rt_D), .Jump_M(Jump_M), .BranchEQ_M(BranchEQ_M),
    .BranchNE_M(BranchNE_M), .Zero_M(Zero_M), .MemRead_M(MemRead_M),
    .MemWrite_M(MemWrite_M), .MemReady(MemReady),
    .Stall_F(a_ctrl[8]), .Stall_D(a_ctrl[7]), .Stall_E(a_ctrl[6]), .Stall_M(a_ctrl[5]),
    .Flush_D(a_ctrl[4]), .Flush_E(a_ctrl[3]), .Flush_M(a_ctrl[2]), .Flush_W(a_ctrl[1]),
    .PCSrc_M(a_ctrl[0]), .Error(a_err), .StallCount(a_count)
  );

  pipeline_hazard_controller #(.MEM_TIMEOUT(B_TIMEOUT), .CNT_W(B_CNT_W)) dut_b (
    .clk(clk), .reset(reset), .MemRead_E(MemRead_E), .WriteReg_E(WriteReg_E),
    .Rs_D(Rs_D), .Rt_D(Rt_D), .Jump_M(Jump_M), .BranchEQ_M(BranchEQ_M),
    .BranchNE_M(BranchNE_M), .Zero_M(Zero_M), .MemRead_M(MemRead_M),
    .MemWrite_M(MemWrite_M), .MemReady(MemReady),
    .Stall_F(b_ctrl[8]), .Stall_D(b_ctrl[7]), .Stall_E(b_ctrl[6]), .Stall_M(b_ctrl[5]),
    .Flush_D(b_ctrl[4]), .Flush_E(b_ctrl[3]), .Flush_M(b_ctrl[2]), .Flush_W(b_ctrl[1]),
    .PCSrc_M(b_ctrl[0]), .Error(b_err), .StallCount(b_count)
  );

  // Model: whether a memory access is outstanding, how many cycles it has
  // stalled so far, whether it timed out, and the total stalled cycles.
  typedef struct {
    int timeout;
    int count_max;
    bit waiting;
    int stalled_run;
    bit dead;
    int count;
  } model_t;

  model_t ma;
  model_t mb;

  function automatic bit m_taken();
    return (BranchEQ_M && Zero_M) || (BranchNE_M && !Zero_M) || (Jump_M != 2'd0);
  endfunction

  function automatic bit m_load_use();
    return MemRead_E && (WriteReg_E != 5'd0) && (WriteReg_E == Rs_D || WriteReg_E == Rt_D);
  endfunction

  function automatic bit m_pending(model_t m);
    if (m.waiting) return !MemReady;
    return (MemRead_M || MemWrite_M) && !MemReady;
  endfunction

  function automatic logic [8:0] model_ctrl(model_t m);
    if (!reset) return C_RESET;
    if (m.dead || m_pending(m)) return C_HOLD;
    if (m_taken()) return C_REDIR;
    if (m_load_use()) return C_BUBBLE;
    return C_IDLE;
  endfunction

  function automatic model_t model_next(model_t m);
    model_t n = m;
    if (!reset) begin
      n.waiting = 0; n.stalled_run = 0; n.dead = 0; n.count = 0;
    end else if (m.dead) begin
      n.count++;
    end else if (m_pending(m)) begin
      n.count++;
      n.stalled_run++;
      n.waiting = 1;
      if (n.stalled_run >= m.timeout) n.dead = 1;
    end else begin
      n.waiting = 0;
      n.stalled_run = 0;
      if (!m_taken() && m_load_use()) n.count++;
    end
    return n;
  endfunction

  function automatic int sat(model_t m);
    return (m.count > m.count_max) ? m.count_max : m.count;
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic set_idle();
    reset = 1'b1; MemRead_E = 1'b0; WriteReg_E = 5'd0; Rs_D = 5'd0; Rt_D = 5'd0;
    Jump_M = 2'd0; BranchEQ_M = 1'b0; BranchNE_M = 1'b0; Zero_M = 1'b0;
    MemRead_M = 1'b0; MemWrite_M = 1'b0; MemReady = 1'b1;
  endtask

  // One clock: combinational outputs checked mid-cycle, registered ones just after the negedge.
  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    last_a_ctrl = a_ctrl;
    last_b_ctrl = b_ctrl;
    check({tag, "_a_ctrl"}, 32'(a_ctrl), 32'(model_ctrl(ma)));
    check({tag, "_b_ctrl"}, 32'(b_ctrl), 32'(model_ctrl(mb)));
    @(negedge clk);
    ma = model_next(ma);
    mb = model_next(mb);
    #1;
    check({tag, "_a_err"}, 32'(a_err), 32'(ma.dead));
    check({tag, "_b_err"}, 32'(b_err), 32'(mb.dead));
    check({tag, "_a_cnt"}, 32'(a_count), 32'(sat(ma)));
    check({tag, "_b_cnt"}, 32'(b_count), 32'(sat(mb)));
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1'b0;
    tick("rst");
    set_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ma = '{A_TIMEOUT, (1 << A_CNT_W) - 1, 0, 0, 0, 0};
    mb = '{B_TIMEOUT, (1 << B_CNT_W) - 1, 0, 0, 0, 0};
    set_idle();

    // Reset held for two cycles, then idle.
    reset = 1'b0;
    tick("t1_rst0");
    check("t1_rst_flush", 32'(last_a_ctrl), 32'(C_RESET));
    tick("t1_rst1");
    set_idle();
    tick("t1_idle");
    check("t1_idle_ctrl", 32'(last_a_ctrl), 32'(C_IDLE));
    check("t1_count", 32'(a_count), 32'd0);

    // Load-use inserts one bubble; r0 never does.
    do_reset();
    MemRead_E = 1'b1; WriteReg_E = 5'd8; Rs_D = 5'd8; Rt_D = 5'd3;
    tick("t2_lu");
    check("t2_bubble", 32'(last_a_ctrl), 32'(C_BUBBLE));
    check("t2_count", 32'(a_count), 32'd1);
    set_idle();
    MemRead_M = 1'b1;
    tick("t2_after");
    check("t2_release", 32'(last_a_ctrl), 32'(C_IDLE));
    MemRead_M = 1'b0;
    MemRead_E = 1'b1; WriteReg_E = 5'd0; Rs_D = 5'd0; Rt_D = 5'd0;
    tick("t2_r0");
    check("t2_r0_ctrl", 32'(last_a_ctrl), 32'(C_IDLE));
    check("t2_r0_count", 32'(a_count), 32'd1);

    // Taken beq overrides load-use; bne with Zero set is not taken.
    set_idle();
    MemRead_E = 1'b1; WriteReg_E = 5'd9; Rt_D = 5'd9; BranchEQ_M = 1'b1; Zero_M = 1'b1;
    tick("t3_beq");
    check("t3_redirect", 32'(last_a_ctrl), 32'(C_REDIR));
    set_idle();
    BranchNE_M = 1'b1; Zero_M = 1'b1;
    tick("t3_bne");
    check("t3_bne_ctrl", 32'(last_a_ctrl), 32'(C_IDLE));
    set_idle();
    Jump_M = 2'd2;
    tick("t3_jump");
    check("t3_jump_ctrl", 32'(last_a_ctrl), 32'(C_REDIR));

    // Three-cycle load, then release in the MemReady cycle.
    do_reset();
    MemRead_M = 1'b1; MemReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick("t4_wait");
      check("t4_hold", 32'(last_a_ctrl), 32'(C_HOLD));
    end
    MemReady = 1'b1;
    tick("t4_ready");
    check("t4_release", 32'(last_a_ctrl), 32'(C_IDLE));
    check("t4_count", 32'(a_count), 32'd3);
    set_idle();
    tick("t4_run");

    // Timeout on the small instance after four stalled cycles.
    do_reset();
    MemWrite_M = 1'b1; MemReady = 1'b0;
    for (int i = 0; i < 3; i++) tick("t5_wait");
    check("t5_err_early", 32'(b_err), 32'd0);
    tick("t5_wait4");
    check("t5_err_set", 32'(b_err), 32'd1);
    MemReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick("t5_stuck");
      check("t5_stuck_hold", 32'(last_b_ctrl), 32'(C_HOLD));
    end
    check("t5_err_sticky", 32'(b_err), 32'd1);
    do_reset();
    check("t5_err_clear", 32'(b_err), 32'd0);

    // 20 stalled cycles: small counter saturates at 15.
    MemRead_M = 1'b1; MemReady = 1'b0;
    for (int i = 0; i < 20; i++) tick("t6_stall");
    check("t6_b_sat", 32'(b_count), 32'd15);
    check("t6_a_count", 32'(a_count), 32'd20);

    // Reset mid-wait returns to RUN with a fresh counter.
    do_reset();
    MemRead_M = 1'b1; MemReady = 1'b0;
    tick("t7_wait");
    tick("t7_wait");
    reset = 1'b0;
    tick("t7_rst");
    set_idle();
    MemWrite_M = 1'b1; MemReady = 1'b0;
    for (int i = 0; i < 3; i++) tick("t7_rewait");
    check("t7_b_no_err", 32'(b_err), 32'd0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 59) != 0);
      MemRead_E  = $urandom_range(0, 1) == 1;
      WriteReg_E = 5'($urandom_range(0, 3));
      Rs_D       = 5'($urandom_range(0, 3));
      Rt_D       = 5'($urandom_range(0, 3));
      Jump_M     = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      BranchEQ_M = $urandom_range(0, 5) == 0;
      BranchNE_M = $urandom_range(0, 5) == 0;
      Zero_M     = $urandom_range(0, 1) == 1;
      MemRead_M  = $urandom_range(0, 3) == 0;
      MemWrite_M = $urandom_range(0, 5) == 0;
      MemReady   = $urandom_range(0, 2) != 0;
      tick("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
